// File: rtl/lcv_div_pkg.sv
// lcv_div_pkg: shared FSM state type and state width for the multi-cycle divider
package lcv_div_pkg;
  localparam int STATE_W = 2;
  typedef enum logic [STATE_W-1:0] {IDLE, RUN, FIX, DONE} state_t;
endpackage

// File: rtl/lcv_div_step.sv
// lcv_div_step: one radix-2 restoring step (shift in a dividend bit, trial subtract, select)
module lcv_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             numer_bit,
  input  logic [WIDTH-1:0] denom,
  output logic [WIDTH-1:0] rem_out,
  output logic             quot_bit
);
  logic [WIDTH:0] shifted, trial;
  assign shifted  = {rem_in, numer_bit};
  assign trial    = shifted - {1'b0, denom};
  assign quot_bit = shifted >= {1'b0, denom};
  assign rem_out  = quot_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
endmodule

// File: rtl/lcv_div_multi_cycle.sv
// lcv_div_multi_cycle: WIDTH-cycle restoring divider with valid/ready handshakes.
// Signed operation is compiled in only when LCV_DIV_SIGNED_EN is defined.
module lcv_div_multi_cycle
  import lcv_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inp_valid,
  output logic             inp_ready,
  input  logic [WIDTH-1:0] inp_numer,
  input  logic [WIDTH-1:0] inp_denom,
  input  logic             inp_signed,
  output logic             outp_valid,
  input  logic             outp_ready,
  output logic [WIDTH-1:0] outp_quot,
  output logic [WIDTH-1:0] outp_rem,
  output logic             outp_div_by_zero
);
  localparam int CW = $clog2(WIDTH);
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] q_work, r_work, d_mag, r_nx;
  logic q_bit, neg_q, neg_r, dbz, sgn, n_neg, d_neg, accept, last;
`ifdef LCV_DIV_SIGNED_EN
  assign sgn = inp_signed;
`else
  assign sgn = inp_signed & 1'b0;
`endif
  assign n_neg  = sgn & inp_numer[WIDTH-1];
  assign d_neg  = sgn & inp_denom[WIDTH-1];
  assign accept = inp_valid & inp_ready;
  assign last   = cnt == CW'(WIDTH - 1);
  // q_work starts as the dividend magnitude and fills with quotient bits from the LSB
  lcv_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in   (r_work),
    .numer_bit(q_work[WIDTH-1]),
    .denom    (d_mag),
    .rem_out  (r_nx),
    .quot_bit (q_bit)
  );
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  always_comb
    state_nx = (state == IDLE && accept)     ? RUN  :
               (state == RUN && last)        ? FIX  :
               (state == FIX)                ? DONE :
               (state == DONE && outp_ready) ? IDLE : state;
  always_comb begin
    inp_ready  = state == IDLE;
    outp_valid = state == DONE;
  end
  // a zero divisor yields all-ones quotient; its sign flip is suppressed so it stays all ones
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt              <= '0;
      q_work           <= '0;
      r_work           <= '0;
      d_mag            <= '0;
      neg_q            <= 1'b0;
      neg_r            <= 1'b0;
      dbz              <= 1'b0;
      outp_quot        <= '0;
      outp_rem         <= '0;
      outp_div_by_zero <= 1'b0;
    end else if (accept) begin
      cnt    <= '0;
      q_work <= n_neg ? -inp_numer : inp_numer;
      d_mag  <= d_neg ? -inp_denom : inp_denom;
      r_work <= '0;
      neg_q  <= n_neg ^ d_neg;
      neg_r  <= n_neg;
      dbz    <= inp_denom == '0;
    end else if (state == RUN) begin
      q_work <= {q_work[WIDTH-2:0], q_bit};
      r_work <= r_nx;
      cnt    <= cnt + CW'(1);
    end else if (state == FIX) begin
      outp_quot        <= (neg_q & ~dbz) ? -q_work : q_work;
      outp_rem         <= neg_r ? -r_work : r_work;
      outp_div_by_zero <= dbz;
    end
  end
endmodule

// File: tb/tb_lcv_div_multi_cycle.sv
// tb_lcv_div_multi_cycle: table-driven directed checks plus backpressure and mid-run reset sequences
module tb_lcv_div_multi_cycle;
  localparam int W = 32;
  logic clk = 1'b0;
  logic rst, inp_valid, inp_ready, inp_signed, outp_valid, outp_ready, outp_div_by_zero;
  logic [W-1:0] inp_numer, inp_denom, outp_quot, outp_rem;
  int n_checks = 0;
  int n_fail = 0;
  typedef struct {
    logic [W-1:0] n, d;
    logic         s;
    logic [W-1:0] q, r;
    logic         z;
    string        name;
  } vec_t;
  vec_t vecs[$];
  lcv_div_multi_cycle #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .inp_valid(inp_valid), .inp_ready(inp_ready),
    .inp_numer(inp_numer), .inp_denom(inp_denom), .inp_signed(inp_signed),
    .outp_valid(outp_valid), .outp_ready(outp_ready), .outp_quot(outp_quot),
    .outp_rem(outp_rem), .outp_div_by_zero(outp_div_by_zero)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic add(input logic [W-1:0] n, d, input logic s, input logic [W-1:0] q, r,
                     input logic z, input string name);
    vec_t v;
    v.n = n; v.d = d; v.s = s; v.q = q; v.r = r; v.z = z; v.name = name;
    vecs.push_back(v);
  endtask
  // called #1 after the accept edge; edges counts rising edges from the accept edge inclusive
  task automatic wait_valid(output int edges);
    edges = 1;
    while (!outp_valid && edges < 200) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask
  task automatic release_result(input string name, input logic [W-1:0] q);
    @(negedge clk); outp_ready = 1'b1;
    @(posedge clk); #1; outp_ready = 1'b0;
    check({name, " valid_drop"}, outp_valid, 0);
    check({name, " ready_back"}, inp_ready, 1);
    check({name, " quot_hold"}, outp_quot, q);
  endtask
  task automatic run_vec(input vec_t v);
    int e;
    @(negedge clk);
    check({v.name, " ready"}, inp_ready, 1);
    inp_valid = 1'b1; inp_numer = v.n; inp_denom = v.d; inp_signed = v.s;
    @(posedge clk); #1;
    inp_valid = 1'b0; inp_numer = $urandom; inp_denom = $urandom; inp_signed = ~v.s;
    check({v.name, " busy"}, inp_ready, 0);
    wait_valid(e);
    check({v.name, " latency"}, 64'(e), 64'(W + 2));
    check({v.name, " quot"}, outp_quot, v.q);
    check({v.name, " rem"}, outp_rem, v.r);
    check({v.name, " dbz"}, outp_div_by_zero, v.z);
    release_result(v.name, v.q);
  endtask
  initial begin
    int e;
    logic seen;
    rst = 1'b1; inp_valid = 1'b0; inp_signed = 1'b0; outp_ready = 1'b0;
    inp_numer = '0; inp_denom = '0;
    add(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, "u100_7");
    add(32'd5, 32'd0, 1'b0, 32'hFFFFFFFF, 32'd5, 1'b1, "u5_0");
    add(32'd7, 32'd100, 1'b0, 32'd0, 32'd7, 1'b0, "u7_100");
    add(32'hFFFFFFFF, 32'd1, 1'b0, 32'hFFFFFFFF, 32'd0, 1'b0, "umax_1");
    add(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, "u9_3");
    add(32'hFFFFFFFB, 32'd0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1, "sm5_0");
`ifdef LCV_DIV_SIGNED_EN
    add(32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, "sm7_2");
    add(32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0, 1'b0, "smin_m1");
    add(32'hFFFFFF9C, 32'd7, 1'b1, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, "sm100_7");
    add(32'd100, 32'hFFFFFFF9, 1'b1, 32'hFFFFFFF2, 32'd2, 1'b0, "s100_m7");
`else
    add(32'hFFFFFFF9, 32'd2, 1'b1, 32'h7FFFFFFC, 32'd1, 1'b0, "sm7_2");
    add(32'h80000000, 32'hFFFFFFFF, 1'b1, 32'd0, 32'h80000000, 1'b0, "smin_m1");
    add(32'hFFFFFF9C, 32'd7, 1'b1, 32'h24924916, 32'd2, 1'b0, "sm100_7");
    add(32'd100, 32'hFFFFFFF9, 1'b1, 32'd0, 32'd100, 1'b0, "s100_m7");
`endif
    add(32'hFFFFFF9C, 32'd7, 1'b0, 32'h24924916, 32'd2, 1'b0, "u_big_7");
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    check("rst valid", outp_valid, 0);
    check("rst quot", outp_quot, 0);
    check("rst rem", outp_rem, 0);
    check("rst dbz", outp_div_by_zero, 0);
    check("rst ready", inp_ready, 1);
    foreach (vecs[i]) run_vec(vecs[i]);
    // backpressure: result held for 10 cycles while a new request waits
    @(negedge clk);
    inp_valid = 1'b1; inp_numer = 32'd100; inp_denom = 32'd7; inp_signed = 1'b0;
    @(posedge clk); #1;
    inp_numer = 32'd9; inp_denom = 32'd3;
    wait_valid(e);
    check("bp latency", 64'(e), 64'(W + 2));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp valid", outp_valid, 1);
      check("bp quot", outp_quot, 14);
      check("bp rem", outp_rem, 2);
      check("bp ready", inp_ready, 0);
    end
    @(negedge clk); outp_ready = 1'b1;
    @(posedge clk); #1; outp_ready = 1'b0;
    check("bp release valid", outp_valid, 0);
    check("bp release ready", inp_ready, 1);
    @(posedge clk); #1; inp_valid = 1'b0;
    check("bp next accepted", inp_ready, 0);
    wait_valid(e);
    check("bp next latency", 64'(e), 64'(W + 2));
    check("bp next quot", outp_quot, 3);
    check("bp next rem", outp_rem, 0);
    release_result("bp next", 32'd3);
    // reset during RUN aborts the operation
    @(negedge clk);
    inp_valid = 1'b1; inp_numer = 32'd100; inp_denom = 32'd7; inp_signed = 1'b0;
    @(posedge clk); #1; inp_valid = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    check("abort ready", inp_ready, 1);
    check("abort valid", outp_valid, 0);
    check("abort quot", outp_quot, 0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      seen |= outp_valid;
    end
    check("abort no result", seen, 0);
    begin
      vec_t v;
      v.n = 32'd9; v.d = 32'd3; v.s = 1'b0; v.q = 32'd3; v.r = 32'd0; v.z = 1'b0; v.name = "post_abort";
      run_vec(v);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
